// File: rtl/sift_sched_pkg.sv
// Shared frame geometry and scheduler state encoding for the SIFT pyramid row scheduler.
package sift_sched_pkg;

    localparam int ROWS  = 480;
    localparam int COLS  = 640;
    localparam int ROW_W = 9;
    localparam int COL_W = 10;
    localparam int HALO  = 3;
    localparam int N_ENG = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        WAIT_MEM = 3'd2,
        BCAST    = 3'd3,
        PAD      = 3'd4,
        DRAIN    = 3'd5,
        DETECT   = 3'd6,
        DONE     = 3'd7
    } sched_state_e;

    // Counters that must never wrap back to a small, misleading value.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sched_done_tracker.sv
// Sticky per-engine completion flags with a synchronous clear and an all-done summary.
module sched_done_tracker #(
    parameter int N_ENG = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [N_ENG-1:0] set_mask,
    output logic [N_ENG-1:0] flags,
    output logic             all_done
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (clear) begin
            // A completion pulse landing on the frame-start edge belongs to the old frame.
            flags <= '0;
        end else if (enable) begin
            flags <= flags | set_mask;
        end
    end

    assign all_done = &flags;

endmodule

// File: rtl/gaussian_row_scheduler.sv
// Frame sequencer: fetch rows, broadcast to Gaussian engines, add halo pads, then run detect.
// Optional performance counters are built when GAUSSIAN_SCHED_PERF_EN is defined.
module gaussian_row_scheduler #(
    parameter int ROWS  = sift_sched_pkg::ROWS,
    parameter int ROW_W = sift_sched_pkg::ROW_W,
    parameter int N_ENG = sift_sched_pkg::N_ENG,
    parameter int HALO  = sift_sched_pkg::HALO
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             mem_rd_en,
    output logic [ROW_W-1:0] mem_rd_addr,
    input  logic             mem_rd_valid,
    output logic             row_valid,
    output logic [ROW_W-1:0] row_idx,
    output logic             row_pad,
    input  logic [N_ENG-1:0] eng_ready,
    input  logic [N_ENG-1:0] eng_done,
    output logic [N_ENG-1:0] gaussian_done,
    output logic             detect_start,
    input  logic             detect_done,
    output logic             frame_done,
    output logic             busy
`ifdef GAUSSIAN_SCHED_PERF_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      frame_cycles
`endif
);

    import sift_sched_pkg::*;

    localparam int PAD_W = (HALO > 0) ? $clog2(HALO + 1) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [PAD_W-1:0] PAD_END  = PAD_W'(HALO);

    sched_state_e     state;
    logic [ROW_W-1:0] row_cnt;
    logic [ROW_W-1:0] row_next;
    logic [PAD_W-1:0] pad_cnt;
    logic [PAD_W-1:0] pad_next;
    logic             all_ready;
    logic             all_done;
    logic             active;
    logic             launch;

    assign row_next  = row_cnt + ROW_W'(1);
    assign pad_next  = pad_cnt + PAD_W'(1);
    assign all_ready = &eng_ready;
    assign active    = (state != IDLE) && (state != DONE);
    assign launch    = !active && start;

    sched_done_tracker #(
        .N_ENG (N_ENG)
    ) u_done_tracker (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (launch),
        .enable   (active),
        .set_mask (eng_done),
        .flags    (gaussian_done),
        .all_done (all_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            row_cnt      <= '0;
            pad_cnt      <= '0;
            mem_rd_en    <= 1'b0;
            mem_rd_addr  <= '0;
            row_valid    <= 1'b0;
            row_idx      <= '0;
            row_pad      <= 1'b0;
            detect_start <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // NOTE: strobes default low here so each branch only raises them for a single cycle.
            mem_rd_en    <= 1'b0;
            detect_start <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= FETCH;
                        row_cnt     <= '0;
                        pad_cnt     <= '0;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= '0;
                        frame_done  <= 1'b0;
                        busy        <= 1'b1;
                    end
                end

                FETCH: begin
                    state <= WAIT_MEM;
                end

                WAIT_MEM: begin
                    if (mem_rd_valid) begin
                        state     <= BCAST;
                        row_valid <= 1'b1;
                        row_idx   <= row_cnt;
                        row_pad   <= 1'b0;
                    end
                end

                BCAST: begin
                    if (all_ready) begin
                        if (row_cnt == ROW_LAST) begin
                            if (HALO == 0) begin
                                state     <= DRAIN;
                                row_valid <= 1'b0;
                            end else begin
                                // Memory still holds the last row, so pads reuse it without a read.
                                state   <= PAD;
                                row_pad <= 1'b1;
                                row_idx <= ROW_LAST;
                            end
                        end else begin
                            state       <= FETCH;
                            row_valid   <= 1'b0;
                            row_cnt     <= row_next;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= row_next;
                        end
                    end
                end

                PAD: begin
                    if (all_ready) begin
                        pad_cnt <= pad_next;
                        if (pad_next == PAD_END) begin
                            state     <= DRAIN;
                            row_valid <= 1'b0;
                            row_pad   <= 1'b0;
                        end
                    end
                end

                DRAIN: begin
                    if (all_done) begin
                        state        <= DETECT;
                        detect_start <= 1'b1;
                    end
                end

                DETECT: begin
                    // detect_done is only trusted once the start pulse has been seen downstream.
                    if (!detect_start && detect_done) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GAUSSIAN_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            frame_cycles <= '0;
        end else if (launch) begin
            stall_cycles <= '0;
            frame_cycles <= '0;
        end else if (active) begin
            frame_cycles <= sat_inc32(frame_cycles);
            if ((state == BCAST || state == PAD) && row_valid && !all_ready) begin
                stall_cycles <= sat_inc32(stall_cycles);
            end
        end
    end
`endif

endmodule

// File: tb/tb_gaussian_row_scheduler.sv
// Directed bench for gaussian_row_scheduler with ROWS=8, HALO=3 and a 1-cycle row memory.
module tb_gaussian_row_scheduler;

    localparam int ROWS  = 8;
    localparam int ROW_W = 9;
    localparam int N_ENG = 4;
    localparam int HALO  = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             mem_rd_valid = 1'b0;
    logic             detect_done = 1'b0;
    logic [N_ENG-1:0] eng_ready = 4'b1111;
    logic [N_ENG-1:0] eng_done = 4'b0000;

    logic             mem_rd_en;
    logic [ROW_W-1:0] mem_rd_addr;
    logic             row_valid;
    logic [ROW_W-1:0] row_idx;
    logic             row_pad;
    logic [N_ENG-1:0] gaussian_done;
    logic             detect_start;
    logic             frame_done;
    logic             busy;
`ifdef GAUSSIAN_SCHED_PERF_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      frame_cycles;
`endif

    always #5 clk = ~clk;

    gaussian_row_scheduler #(
        .ROWS  (ROWS),
        .ROW_W (ROW_W),
        .N_ENG (N_ENG),
        .HALO  (HALO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mem_rd_en     (mem_rd_en),
        .mem_rd_addr   (mem_rd_addr),
        .mem_rd_valid  (mem_rd_valid),
        .row_valid     (row_valid),
        .row_idx       (row_idx),
        .row_pad       (row_pad),
        .eng_ready     (eng_ready),
        .eng_done      (eng_done),
        .gaussian_done (gaussian_done),
        .detect_start  (detect_start),
        .detect_done   (detect_done),
        .frame_done    (frame_done),
        .busy          (busy)
`ifdef GAUSSIAN_SCHED_PERF_EN
        ,
        .stall_cycles  (stall_cycles),
        .frame_cycles  (frame_cycles)
`endif
    );

    int total = 0;
    int bad = 0;

    // Row memory: valid pulses in the cycle after the read request.
    logic rd_seen = 1'b0;
    always @(posedge clk) begin
        #1;
        mem_rd_valid = rd_seen;
        rd_seen = mem_rd_en;
    end

    // Transaction recorder, sampled mid-cycle.
    logic mon_clr = 1'b0;
    int   ncyc = 0;
    int   t0 = 0;
    int   rd_cnt = 0;
    int   xf_cnt = 0;
    int   ds_cnt = 0;
    int   rd_addr [16];
    int   xf_t    [16];
    int   xf_idx  [16];
    logic xf_pad  [16];

    always @(negedge clk) begin
        ncyc++;
        if (mon_clr) begin
            rd_cnt = 0;
            xf_cnt = 0;
            ds_cnt = 0;
        end else begin
            if (mem_rd_en) begin
                if (rd_cnt == 0) t0 = ncyc;
                if (rd_cnt < 16) rd_addr[rd_cnt] = int'(mem_rd_addr);
                rd_cnt++;
            end
            if (row_valid && (&eng_ready)) begin
                if (xf_cnt < 16) begin
                    xf_t[xf_cnt]   = ncyc - t0;
                    xf_idx[xf_cnt] = int'(row_idx);
                    xf_pad[xf_cnt] = row_pad;
                end
                xf_cnt++;
            end
            if (detect_start) ds_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_monitor();
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_rd_addr", mem_rd_addr, 0);
        check("rst_row_valid", row_valid, 0);
        check("rst_row_idx", row_idx, 0);
        check("rst_row_pad", row_pad, 0);
        check("rst_gaussian_done", gaussian_done, 0);
        check("rst_detect_start", detect_start, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        tick();
        check("idle_stays_idle", busy, 0);

        // Frame A: clean run, 1-cycle memory, engines always ready
        clear_monitor();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("a_first_rd_en", mem_rd_en, 1);
        check("a_first_rd_addr", mem_rd_addr, 0);
        check("a_busy", busy, 1);

        for (int n = 0; n < 60 && !(row_valid && row_idx == 9'd3); n++) tick();
        check("a_reach_row3", (row_valid && row_idx == 9'd3), 1);
        eng_done = 4'b0001;
        tick();
        eng_done = 4'b0000;
        check("a_gd_after_eng0", gaussian_done, 4'b0001);

        for (int n = 0; n < 60 && xf_cnt < 11; n++) tick();
        check("a_xfer_budget", (xf_cnt >= 11), 1);
        tick();
        tick();
        tick();
        check("a_drain_no_detect", detect_start, 0);
        check("a_drain_busy", busy, 1);
        check("a_drain_gd", gaussian_done, 4'b0001);
        check("a_drain_no_rd", mem_rd_en, 0);
        eng_done = 4'b1110;
        tick();
        eng_done = 4'b0000;
        check("a_gd_all", gaussian_done, 4'b1111);
        check("a_detect_not_yet", detect_start, 0);
        tick();
        check("a_detect_start", detect_start, 1);
        tick();
        check("a_detect_start_drop", detect_start, 0);
        tick();
        tick();
        tick();
        detect_done = 1'b1;
        check("a_frame_not_done", frame_done, 0);
        tick();
        detect_done = 1'b0;
        check("a_frame_done", frame_done, 1);
        check("a_done_busy", busy, 0);
`ifdef GAUSSIAN_SCHED_PERF_EN
        check("a_frame_cycles", frame_cycles, 37);
        check("a_stall_cycles", stall_cycles, 0);
`endif
        check("a_rd_count", rd_cnt, 8);
        for (int i = 0; i < 8; i++) check($sformatf("a_rd_addr%0d", i), rd_addr[i], i);
        check("a_xfer_count", xf_cnt, 11);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("a_xfer_t%0d", i), xf_t[i], (i < 8) ? 3 * i + 2 : 24 + (i - 8));
            check($sformatf("a_xfer_idx%0d", i), xf_idx[i], (i < 8) ? i : 7);
            check($sformatf("a_xfer_pad%0d", i), xf_pad[i], (i >= 8) ? 1 : 0);
        end
        check("a_detect_pulses", ds_cnt, 1);

        // Frame B: restart from DONE with a same-edge eng_done, stall on row 2, stray inputs
        clear_monitor();
        check("a_sticky_done", frame_done, 1);
        start = 1'b1;
        eng_done = 4'b1111;
        tick();
        eng_done = 4'b0000;
        check("b_gd_cleared", gaussian_done, 0);
        check("b_frame_cleared", frame_done, 0);
        check("b_rd_en", mem_rd_en, 1);
        check("b_rd_addr0", mem_rd_addr, 0);
        tick();
        tick();
        tick();
        start = 1'b0;

        for (int n = 0; n < 40 && !(mem_rd_en && mem_rd_addr == 9'd2); n++) tick();
        check("b_reach_fetch2", (mem_rd_en && mem_rd_addr == 9'd2), 1);
        eng_ready = 4'b1011;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("b_stall_valid%0d", i), row_valid, 1);
            check($sformatf("b_stall_idx%0d", i), row_idx, 2);
            check($sformatf("b_stall_no_rd%0d", i), mem_rd_en, 0);
            detect_done = (i == 1);
            tick();
        end
        detect_done = 1'b0;
        eng_ready = 4'b1111;
        check("b_hold_valid", row_valid, 1);
        check("b_hold_idx", row_idx, 2);
        tick();
        check("b_fetch3_en", mem_rd_en, 1);
        check("b_fetch3_addr", mem_rd_addr, 3);
        check("b_fetch3_valid_low", row_valid, 0);
`ifdef GAUSSIAN_SCHED_PERF_EN
        check("b_stall_cycles", stall_cycles, 5);
`endif

        for (int n = 0; n < 40 && !(row_valid && row_idx == 9'd4); n++) tick();
        check("b_reach_row4", (row_valid && row_idx == 9'd4), 1);
        eng_done = 4'b1111;
        tick();
        eng_done = 4'b0000;
        for (int n = 0; n < 80 && !detect_start; n++) tick();
        check("b_detect_start", detect_start, 1);
        detect_done = 1'b1;
        tick();
        detect_done = 1'b0;
        check("b_early_detect_ignored_busy", busy, 1);
        check("b_early_detect_ignored_done", frame_done, 0);
        tick();
        detect_done = 1'b1;
        tick();
        detect_done = 1'b0;
        check("b_frame_done", frame_done, 1);
        check("b_done_busy", busy, 0);
        check("b_rd_count", rd_cnt, 8);
        for (int i = 0; i < 8; i++) check($sformatf("b_rd_addr%0d", i), rd_addr[i], i);
        check("b_xfer_count", xf_cnt, 11);
        check("b_xfer_t2", xf_t[2], 13);
        check("b_xfer_t3", xf_t[3], 16);
        check("b_detect_pulses", ds_cnt, 1);

        // Frame C: reset while waiting on the memory for row 5
        start = 1'b1;
        tick();
        start = 1'b0;
        check("c_gd_cleared", gaussian_done, 0);
        eng_done = 4'b0100;
        tick();
        eng_done = 4'b0000;
        for (int n = 0; n < 40 && !(mem_rd_en && mem_rd_addr == 9'd5); n++) tick();
        check("c_reach_fetch5", (mem_rd_en && mem_rd_addr == 9'd5), 1);
        tick();
        check("c_wait_mem_busy", busy, 1);
        check("c_wait_mem_gd", gaussian_done, 4'b0100);
        rst_n = 1'b0;
        tick();
        check("c_rst_busy", busy, 0);
        check("c_rst_rd_en", mem_rd_en, 0);
        check("c_rst_rd_addr", mem_rd_addr, 0);
        check("c_rst_row_valid", row_valid, 0);
        check("c_rst_row_idx", row_idx, 0);
        check("c_rst_row_pad", row_pad, 0);
        check("c_rst_gd", gaussian_done, 0);
        check("c_rst_frame_done", frame_done, 0);
        check("c_rst_detect_start", detect_start, 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("c_idle_no_rd", mem_rd_en, 0);
        check("c_idle_busy", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("c_restart_rd_en", mem_rd_en, 1);
        check("c_restart_rd_addr", mem_rd_addr, 0);
        tick();
        tick();
        check("c_restart_row_valid", row_valid, 1);
        check("c_restart_row_idx", row_idx, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gaussian_row_scheduler.md
Name: gaussian_row_scheduler

Overview:
- Sequences one frame of pyramid construction in CORE.
- Fetches original-image rows one at a time from the row-wide image memory and broadcasts each row to the four Gaussian engines (3x3, 5x5, 5x5, 7x7).
- Appends halo pad rows, collects per-engine completion into gaussian_done[3:0], then launches and waits on the keypoint detect/filter stage.
- Sits between the top-level in_valid start and the ori_img / blur / detect resources.

Parameters:
- ROWS, 480, image rows per frame.
- ROW_W, 9, row-index width; must satisfy 2**ROW_W >= ROWS.
- N_ENG, 4, number of Gaussian engines.
- HALO, 3, pad rows appended after the last row; the 7x7 half-width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  frame start, driven from in_valid
- mem_rd_en  out  1  one-cycle read request to the image row memory
- mem_rd_addr  out  ROW_W  row address for the read
- mem_rd_valid  in  1  one-cycle pulse; row data is valid and held by the memory until the next mem_rd_en
- row_valid  out  1  row broadcast valid to all engines
- row_idx  out  ROW_W  index of the row being broadcast
- row_pad  out  1  1 = halo pad row (replicated last row)
- eng_ready  in  N_ENG  per-engine accept
- eng_done  in  N_ENG  per-engine completion pulse
- gaussian_done  out  N_ENG  sticky per-engine done flags
- detect_start  out  1  one-cycle pulse to the detect/filter stage
- detect_done  in  1  detect/filter completion pulse
- frame_done  out  1  sticky frame complete flag
- busy  out  1  high in every state except IDLE and DONE

Behaviour:
- Reset (rst_n=0 at a rising clk edge): state=IDLE; all outputs 0; row counter 0; pad counter 0.
- IDLE: start=1 -> FETCH; gaussian_done and frame_done cleared on that edge.
- FETCH: mem_rd_en=1 for exactly one cycle, mem_rd_addr=row counter -> WAIT_MEM.
- WAIT_MEM: wait for mem_rd_valid, any latency, no timeout -> BCAST.
- BCAST: row_valid=1; row_idx and row_pad stable while row_valid is high.
  - Transfer occurs in a cycle with row_valid & (&eng_ready). All engines accept in the same cycle; partial readiness does not transfer.
  - On transfer, with a real row: if row counter == ROWS-1 -> PAD; else increment the counter -> FETCH.
  - On transfer, with a pad row: increment the pad counter; if pad count reaches HALO -> DRAIN, else stay in PAD.
  - No new memory read is issued until the current broadcast has transferred.
- PAD: no memory read. Broadcast with row_pad=1, row_idx=ROWS-1; the memory still holds the last row. Same transfer rule as BCAST.
- DRAIN: wait until gaussian_done == all ones -> DETECT.
- DETECT: detect_start=1 on the first cycle only. detect_done is sampled from the following cycle onward. detect_done -> DONE.
- DONE: frame_done=1 (sticky); busy=0. start=1 -> FETCH with flags cleared, exactly as from IDLE.
- Throughput: one real row per 3 cycles minimum (FETCH, WAIT_MEM, BCAST) when mem latency is 1 and engines are always ready.
- eng_done[k] sets gaussian_done[k] in any state except IDLE and DONE, including mid-BCAST. Early or duplicate pulses are harmless.
- Edge cases:
  - eng_done in the same cycle as the clearing start: clear wins.
  - start while busy: ignored.
  - detect_done outside DETECT: ignored.
  - Reset mid-operation: returns everything to reset values on the next edge. No partial-frame resume.
  - HALO=0: the last real transfer goes straight to DRAIN.

Optional Feature:
- Macro: GAUSSIAN_SCHED_PERF_EN.
- With the macro defined, the block adds two outputs:
  - stall_cycles, 32 bits: counts BCAST/PAD cycles with row_valid=1 and &eng_ready=0.
  - frame_cycles, 32 bits: counts all busy cycles.
  - Both clear on a frame start, saturate at all ones, and hold their value in DONE.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package sift_sched_pkg:
  - state enum: IDLE, FETCH, WAIT_MEM, BCAST, PAD, DRAIN, DETECT, DONE.
  - constants: ROWS=480, COLS=640, ROW_W=9, COL_W=10, HALO=3.
- Sub-module sched_done_tracker: sticky N_ENG-bit flag register with clear and an all-done output. Instantiated once.

Test Plan:
- Reset and start with ROWS=8, HALO=3, mem latency 1, eng_ready=4'b1111:
  - 8 mem_rd_en pulses, addresses 0..7.
  - 11 row_valid transfers; the last 3 have row_pad=1 and row_idx=7.
  - Cycles 0..23 carry the real rows; transfers occur every 3rd cycle.
- Hold eng_ready=4'b1011 for 5 cycles during row 2:
  - row_valid and row_idx=2 stay stable; no mem_rd_en is issued.
  - Transfer occurs on the first cycle with 4'b1111; stall_cycles=5 with GAUSSIAN_SCHED_PERF_EN.
- Pulse eng_done 4'b0001 during BCAST of row 3, then 4'b1110 after the pads:
  - gaussian_done goes 0001, then 1111.
  - detect_start pulses once, on the cycle after DRAIN exits.
- detect_done pulse 4 cycles after detect_start:
  - frame_done=1 and busy=0 from the next edge.
  - A new start clears frame_done and gaussian_done, and mem_rd_addr=0.
- rst_n=0 for one edge while in WAIT_MEM of row 5:
  - All outputs 0 and state IDLE next cycle.
  - The next start refetches from row 0.
- start asserted while busy, and detect_done pulsed during BCAST: no effect on sequencing.
